// File: rtl/rgmii_tx_ddr_gen.sv
// RGMII transmit DDR half-word generator: turns a GMII byte stream into per-cycle
// rising/falling halves for TXD, TX_CTL and the forwarded TXC, at 1000/100/10 Mb/s.
module rgmii_tx_ddr_gen #(
    parameter int DIV_100M = 5,
    parameter int DIV_10M  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_clk_en,
    output logic [3:0] txd_q1,
    output logic [3:0] txd_q2,
    output logic       tx_ctl_q1,
    output logic       tx_ctl_q2,
    output logic       txc_q1,
    output logic       txc_q2
);
    localparam int MAX_DIV = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
    localparam int CW      = $clog2(MAX_DIV + 1);

    localparam logic [CW-1:0] LAST_10M  = CW'(DIV_10M - 1);
    localparam logic [CW-1:0] LAST_100M = CW'(DIV_100M - 1);
    localparam logic [CW-1:0] HALF_10M  = CW'(DIV_10M / 2);
    localparam logic [CW-1:0] HALF_100M = CW'(DIV_100M / 2);
    localparam logic          ODD_10M   = (DIV_10M % 2) != 0;
    localparam logic          ODD_100M  = (DIV_100M % 2) != 0;

    logic [1:0]    speed_q, speed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    byte_q, byte_d;
    logic          en_q, en_d;
    logic          er_q, er_d;

    logic          gmii_clk_en_q, gmii_clk_en_d;
    logic [3:0]    txd_q1_q, txd_q1_d;
    logic [3:0]    txd_q2_q, txd_q2_d;
    logic          tx_ctl_q1_q, tx_ctl_q1_d;
    logic          tx_ctl_q2_q, tx_ctl_q2_d;
    logic          txc_q1_q, txc_q1_d;
    logic          txc_q2_q, txc_q2_d;

    logic          speed_chg;
    logic          fast;
    logic [CW-1:0] last_cnt;
    logic [CW-1:0] half_cnt;
    logic          div_odd;
    logic [3:0]    nibble;

    always_comb begin
        speed_chg = (speed != speed_q);
        speed_d   = speed_chg ? speed : speed_q;
        fast      = speed_d[1];
        last_cnt  = (speed_d == 2'd0) ? LAST_10M : LAST_100M;
        half_cnt  = (speed_d == 2'd0) ? HALF_10M : HALF_100M;
        div_odd   = (speed_d == 2'd0) ? ODD_10M  : ODD_100M;

        cnt_d   = cnt_q;
        phase_d = phase_q;
        byte_d  = byte_q;
        en_d    = en_q;
        er_d    = er_q;

        // A speed change restarts pacing and idles the line for one cycle.
        if (speed_chg) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            en_d    = 1'b0;
            er_d    = 1'b0;
        end else begin
            if (gmii_clk_en_q) begin
                byte_d = gmii_txd;
                en_d   = gmii_tx_en;
                er_d   = gmii_tx_er;
            end
            if (fast) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q == last_cnt) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Outputs are registered from next state so they line up with cnt/phase.
        nibble      = phase_d ? byte_d[7:4] : byte_d[3:0];
        tx_ctl_q1_d = en_d;
        tx_ctl_q2_d = en_d ^ er_d;
        if (fast) begin
            txd_q1_d      = byte_d[3:0];
            txd_q2_d      = byte_d[7:4];
            txc_q1_d      = 1'b1;
            txc_q2_d      = 1'b0;
            gmii_clk_en_d = ~speed_chg;
        end else begin
            txd_q1_d      = nibble;
            txd_q2_d      = nibble;
            txc_q1_d      = (cnt_d < half_cnt) || ((cnt_d == half_cnt) && div_odd);
            txc_q2_d      = (cnt_d < half_cnt);
            gmii_clk_en_d = ~speed_chg && (cnt_d == last_cnt) && phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q       <= speed;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            byte_q        <= 8'h00;
            en_q          <= 1'b0;
            er_q          <= 1'b0;
            gmii_clk_en_q <= 1'b0;
            txd_q1_q      <= 4'h0;
            txd_q2_q      <= 4'h0;
            tx_ctl_q1_q   <= 1'b0;
            tx_ctl_q2_q   <= 1'b0;
            txc_q1_q      <= 1'b0;
            txc_q2_q      <= 1'b0;
        end else begin
            speed_q       <= speed_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            byte_q        <= byte_d;
            en_q          <= en_d;
            er_q          <= er_d;
            gmii_clk_en_q <= gmii_clk_en_d;
            txd_q1_q      <= txd_q1_d;
            txd_q2_q      <= txd_q2_d;
            tx_ctl_q1_q   <= tx_ctl_q1_d;
            tx_ctl_q2_q   <= tx_ctl_q2_d;
            txc_q1_q      <= txc_q1_d;
            txc_q2_q      <= txc_q2_d;
        end
    end

    assign gmii_clk_en = gmii_clk_en_q;
    assign txd_q1      = txd_q1_q;
    assign txd_q2      = txd_q2_q;
    assign tx_ctl_q1   = tx_ctl_q1_q;
    assign tx_ctl_q2   = tx_ctl_q2_q;
    assign txc_q1      = txc_q1_q;
    assign txc_q2      = txc_q2_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// Testbench for rgmii_tx_ddr_gen: vector table at 1000M, paced nibble runs at
// 100M/10M, speed-change and reset corner cases, then random traffic vs a model.
module tb_rgmii_tx_ddr_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'd2;
    logic [7:0] gmii_txd = 8'h00;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic       gmii_clk_en;
    logic [3:0] txd_q1, txd_q2;
    logic       tx_ctl_q1, tx_ctl_q2, txc_q1, txc_q2;

    int total = 0;
    int bad   = 0;

    rgmii_tx_ddr_gen #(.DIV_100M(5), .DIV_10M(50)) dut (
        .clk(clk), .rst(rst), .speed(speed),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_clk_en(gmii_clk_en),
        .txd_q1(txd_q1), .txd_q2(txd_q2),
        .tx_ctl_q1(tx_ctl_q1), .tx_ctl_q2(tx_ctl_q2),
        .txc_q1(txc_q1), .txc_q2(txc_q2)
    );

    always #4 clk = ~clk;

    // Reference model: time since the last restart, line speed and the captured byte.
    logic       m_rst_cycle = 1'b1;
    logic       m_chg_cycle = 1'b0;
    logic [1:0] m_spd = 2'd2;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_en = 1'b0, m_er = 1'b0;

    logic       e_clk_en, e_ctl1, e_ctl2, e_txc1, e_txc2;
    logic [3:0] e_txd1, e_txd2;

    logic       s_clk_en, s_ctl1, s_ctl2, s_txc1, s_txc2;
    logic [3:0] s_txd1, s_txd2;

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic       er;
        logic [3:0] q1;
        logic [3:0] q2;
        logic       c1;
        logic       c2;
    } vec_t;
    vec_t vecs[6];

    function automatic int div_of(input logic [1:0] s);
        return (s == 2'd0) ? 50 : ((s == 2'd1) ? 5 : 0);
    endfunction

    task automatic compute_expected();
        int dv;
        int c;
        logic [3:0] nib;
        dv = div_of(m_spd);
        if (m_rst_cycle) begin
            {e_clk_en, e_ctl1, e_ctl2, e_txc1, e_txc2} = 5'b0;
            e_txd1 = 4'h0;
            e_txd2 = 4'h0;
        end else begin
            e_ctl1 = m_en;
            e_ctl2 = m_en ^ m_er;
            if (dv == 0) begin
                e_txd1   = m_byte[3:0];
                e_txd2   = m_byte[7:4];
                e_txc1   = 1'b1;
                e_txc2   = 1'b0;
                e_clk_en = !m_chg_cycle;
            end else begin
                c        = m_t % dv;
                nib      = (((m_t / dv) % 2) == 1) ? m_byte[7:4] : m_byte[3:0];
                e_txd1   = nib;
                e_txd2   = nib;
                e_txc1   = (2 * c) < dv;
                e_txc2   = (2 * c + 1) < dv;
                e_clk_en = !m_chg_cycle && (m_t == 2 * dv - 1);
            end
        end
    endtask

    task automatic advance_model();
        int dv;
        if (rst) begin
            m_rst_cycle = 1'b1;
            m_chg_cycle = 1'b0;
            m_spd = speed;
            m_t = 0;
            m_byte = 8'h00;
            m_en = 1'b0;
            m_er = 1'b0;
        end else if (speed != m_spd) begin
            m_rst_cycle = 1'b0;
            m_chg_cycle = 1'b1;
            m_spd = speed;
            m_t = 0;
            m_en = 1'b0;
            m_er = 1'b0;
        end else begin
            if (e_clk_en) begin
                m_byte = gmii_txd;
                m_en = gmii_tx_en;
                m_er = gmii_tx_er;
            end
            dv = div_of(m_spd);
            m_t = (dv == 0) ? 0 : (m_t + 1) % (2 * dv);
            m_rst_cycle = 1'b0;
            m_chg_cycle = 1'b0;
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        check_val("gmii_clk_en", 8'(gmii_clk_en), 8'(e_clk_en));
        check_val("txd_q1", 8'(txd_q1), 8'(e_txd1));
        check_val("txd_q2", 8'(txd_q2), 8'(e_txd2));
        check_val("tx_ctl_q1", 8'(tx_ctl_q1), 8'(e_ctl1));
        check_val("tx_ctl_q2", 8'(tx_ctl_q2), 8'(e_ctl2));
        check_val("txc_q1", 8'(txc_q1), 8'(e_txc1));
        check_val("txc_q2", 8'(txc_q2), 8'(e_txc2));
    endtask

    // Drives one cycle's inputs, checks that cycle against the model, then steps it.
    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [7:0] d,
                                 input logic en, input logic er);
        @(negedge clk);
        rst = r;
        speed = s;
        gmii_txd = d;
        gmii_tx_en = en;
        gmii_tx_er = er;
        compute_expected();
        checkOutput();
        s_clk_en = gmii_clk_en;
        s_txd1 = txd_q1;
        s_txd2 = txd_q2;
        s_ctl1 = tx_ctl_q1;
        s_ctl2 = tx_ctl_q2;
        s_txc1 = txc_q1;
        s_txc2 = txc_q2;
        @(posedge clk);
        advance_model();
    endtask

    // Waits for a capture slot, sends one byte, and checks the full two-nibble period.
    task automatic nibble_run(input logic [1:0] spd, input logic [7:0] b, input int dv);
        bit found = 0;
        for (int k = 0; k < 4 * dv + 4; k++) begin
            compute_expected();
            if (e_clk_en) begin
                found = 1;
                break;
            end
            applyStimulus(1'b0, spd, 8'h00, 1'b0, 1'b0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL run_wait_slot at %0t: no gmii_clk_en within budget", $time);
        end
        applyStimulus(1'b0, spd, b, 1'b1, 1'b0);
        for (int k = 0; k < 2 * dv; k++) begin
            applyStimulus(1'b0, spd, 8'h00, 1'b1, 1'b0);
            check_val("run_txd1", 8'(s_txd1), 8'((k < dv) ? b[3:0] : b[7:4]));
            check_val("run_txd2", 8'(s_txd2), 8'((k < dv) ? b[3:0] : b[7:4]));
            check_val("run_txc", 8'({s_txc1, s_txc2}),
                      8'({(2 * (k % dv)) < dv, (2 * (k % dv) + 1) < dv}));
            check_val("run_clk_en", 8'(s_clk_en), 8'(k == 2 * dv - 1));
            check_val("run_ctl", 8'({s_ctl1, s_ctl2}), 8'h03);
        end
    endtask

    initial begin
        int idx;
        int guard;
        logic [1:0] rspd;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 4'h5, 4'h5, 1'b1, 1'b1};
        vecs[1] = '{8'hD5, 1'b1, 1'b0, 4'h5, 4'hD, 1'b1, 1'b1};
        vecs[2] = '{8'hA3, 1'b1, 1'b0, 4'h3, 4'hA, 1'b1, 1'b1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 4'hC, 4'h3, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[5] = '{8'hF0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};

        @(negedge clk);
        @(posedge clk);
        advance_model();
        applyStimulus(1'b1, 2'd2, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);

        // Gigabit: one byte per cycle, each shown the following cycle.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) applyStimulus(1'b0, 2'd2, vecs[i].d, vecs[i].en, vecs[i].er);
            else       applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
            if (i > 0) begin
                check_val("vec_txd1", 8'(s_txd1), 8'(vecs[i-1].q1));
                check_val("vec_txd2", 8'(s_txd2), 8'(vecs[i-1].q2));
                check_val("vec_ctl1", 8'(s_ctl1), 8'(vecs[i-1].c1));
                check_val("vec_ctl2", 8'(s_ctl2), 8'(vecs[i-1].c2));
                check_val("vec_txc", 8'({s_txc1, s_txc2}), 8'h02);
                check_val("vec_clk_en", 8'(s_clk_en), 8'h01);
            end
        end

        applyStimulus(1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
        nibble_run(2'd1, 8'hA3, 5);

        // Switch to gigabit in the middle of a 100M frame.
        applyStimulus(1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
        check_val("chg_clk_en", 8'(s_clk_en), 8'h00);
        check_val("chg_ctl", 8'({s_ctl1, s_ctl2}), 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
            check_val("post_chg_clk_en", 8'(s_clk_en), 8'h01);
            check_val("post_chg_txc", 8'({s_txc1, s_txc2}), 8'h02);
        end

        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        nibble_run(2'd0, 8'h7E, 50);

        // Reset in the second nibble of a 10M byte (cnt=30, phase=1).
        guard = 0;
        while (m_t != 80 && guard < 300) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
            guard++;
        end
        total++;
        if (m_t != 80) begin
            bad++;
            $display("[TB] FAIL rst_position at %0t: never reached cnt=30 phase=1", $time);
        end
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
        idx = -1;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
            if (n == 0) begin
                check_val("rst_txd", 8'({s_txd1, s_txd2}), 8'h00);
                check_val("rst_ctl_txc", 8'({s_clk_en, s_ctl1, s_ctl2, s_txc1, s_txc2}), 8'h00);
            end
            if (s_clk_en === 1'b1) begin
                idx = n;
                break;
            end
        end
        total++;
        if (idx != 99) begin
            bad++;
            $display("[TB] FAIL first_pulse_after_rst: got cycle %0d, expected 99", idx);
        end

        // Random traffic with occasional resets and speed changes.
        rspd = 2'd2;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) rspd = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 199) == 0), rspd, 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
